// File: rtl/vector_register_file.sv
// Vector register file: REG_COUNT x LANES x LANE_WIDTH storage, two read ports, a masked write port,
// a busy scoreboard and a lane-serial load engine. Define VREG_WRITE_BYPASS_EN to forward same-cycle writes to reads.
module vector_register_file #(
  parameter int LANE_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int REG_COUNT  = 8,
  localparam int SEL_W     = $clog2(REG_COUNT)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SEL_W-1:0]            rSel1,
  input  logic [SEL_W-1:0]            rSel2,
  output logic [LANES*LANE_WIDTH-1:0] reg1Out,
  output logic [LANES*LANE_WIDTH-1:0] reg2Out,
  input  logic                        regWrEn,
  input  logic [SEL_W-1:0]            regToWrite,
  input  logic [LANES-1:0]            wrMask,
  input  logic [LANES*LANE_WIDTH-1:0] dataIn,
  input  logic                        reserveEn,
  input  logic [SEL_W-1:0]            reserveSel,
  output logic [REG_COUNT-1:0]        busy,
  input  logic                        ldStart,
  input  logic [SEL_W-1:0]            ldSel,
  input  logic                        ldValid,
  input  logic [LANE_WIDTH-1:0]       ldData,
  output logic                        ldReady,
  output logic                        ldDone
);

  localparam int CNT_W = $clog2(LANES);
  localparam int VW    = LANES * LANE_WIDTH;

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} ld_state_e;

  ld_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0]       ld_sel_q, ld_sel_d;
  logic [REG_COUNT-1:0]   busy_q, busy_d;
  logic                   ld_ready_q, ld_ready_d;
  logic                   ld_done_q, ld_done_d;
  logic [VW-1:0]          mem_q [REG_COUNT];
  logic                   ld_beat_s, ld_last_s;
  logic [REG_COUNT-1:0]   wr_clr_s, ld_clr_s, ld_set_s, rsv_set_s;
  logic [VW-1:0]          rd1_s, rd2_s;

  assign ld_beat_s = (state_q == LOAD) && ldValid;
  assign ld_last_s = ld_beat_s && (cnt_q == CNT_W'(LANES - 1));

  // Load engine next state: capture target on start, advance one lane per valid beat.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_sel_d  = ld_sel_q;
    ld_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ldStart) begin
          state_d  = LOAD;
          cnt_d    = '0;
          ld_sel_d = ldSel;
        end else begin
          state_d  = IDLE;
        end
      end
      LOAD: begin
        if (ld_last_s) begin
          state_d   = IDLE;
          cnt_d     = '0;
          ld_done_d = 1'b1;
        end else if (ld_beat_s) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    ld_ready_d = (state_d == LOAD);
  end

  // Scoreboard: clears applied first so any same-cycle set wins; the loading register stays busy until its last beat.
  always_comb begin
    wr_clr_s  = (regWrEn && !((state_q == LOAD) && (regToWrite == ld_sel_q)))
              ? (REG_COUNT'(1) << regToWrite) : '0;
    ld_clr_s  = ld_last_s ? (REG_COUNT'(1) << ld_sel_q) : '0;
    ld_set_s  = ((state_q == IDLE) && ldStart) ? (REG_COUNT'(1) << ldSel) : '0;
    rsv_set_s = reserveEn ? (REG_COUNT'(1) << reserveSel) : '0;
    busy_d    = (busy_q & ~wr_clr_s & ~ld_clr_s) | ld_set_s | rsv_set_s;
  end

  // Control and scoreboard registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ld_sel_q   <= '0;
      busy_q     <= '0;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_sel_q   <= ld_sel_d;
      busy_q     <= busy_d;
      ld_ready_q <= ld_ready_d;
      ld_done_q  <= ld_done_d;
    end
  end

  // Lane storage: a load beat outranks a masked execution write on the same lane.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < REG_COUNT; r++) mem_q[r] <= '0;
    end else begin
      for (int r = 0; r < REG_COUNT; r++) begin
        for (int l = 0; l < LANES; l++) begin
          if (ld_beat_s && (ld_sel_q == SEL_W'(r)) && (cnt_q == CNT_W'(l)))
            mem_q[r][l*LANE_WIDTH +: LANE_WIDTH] <= ldData;
          else if (regWrEn && (regToWrite == SEL_W'(r)) && wrMask[l])
            mem_q[r][l*LANE_WIDTH +: LANE_WIDTH] <= dataIn[l*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // Read ports, optionally forwarding the in-flight writes lane by lane.
  always_comb begin
    rd1_s = mem_q[rSel1];
    rd2_s = mem_q[rSel2];
`ifdef VREG_WRITE_BYPASS_EN
    for (int l = 0; l < LANES; l++) begin
      if (ld_beat_s && (cnt_q == CNT_W'(l)) && (ld_sel_q == rSel1))
        rd1_s[l*LANE_WIDTH +: LANE_WIDTH] = ldData;
      else if (regWrEn && wrMask[l] && (regToWrite == rSel1))
        rd1_s[l*LANE_WIDTH +: LANE_WIDTH] = dataIn[l*LANE_WIDTH +: LANE_WIDTH];
      else
        rd1_s[l*LANE_WIDTH +: LANE_WIDTH] = mem_q[rSel1][l*LANE_WIDTH +: LANE_WIDTH];
      if (ld_beat_s && (cnt_q == CNT_W'(l)) && (ld_sel_q == rSel2))
        rd2_s[l*LANE_WIDTH +: LANE_WIDTH] = ldData;
      else if (regWrEn && wrMask[l] && (regToWrite == rSel2))
        rd2_s[l*LANE_WIDTH +: LANE_WIDTH] = dataIn[l*LANE_WIDTH +: LANE_WIDTH];
      else
        rd2_s[l*LANE_WIDTH +: LANE_WIDTH] = mem_q[rSel2][l*LANE_WIDTH +: LANE_WIDTH];
    end
`endif
  end

  assign reg1Out = rd1_s;
  assign reg2Out = rd2_s;
  assign busy    = busy_q;
  assign ldReady = ld_ready_q;
  assign ldDone  = ld_done_q;

endmodule

// File: tb/tb_vector_register_file.sv
// Randomized and directed bench for vector_register_file against a lane-array reference model.
module tb_vector_register_file;
  localparam int LW = 8;
  localparam int LN = 4;
  localparam int RC = 8;
  localparam int SW = 3;
  localparam int VW = LN * LW;

  logic          clk, reset;
  logic [SW-1:0] rSel1, rSel2, regToWrite, reserveSel, ldSel;
  logic [VW-1:0] reg1Out, reg2Out, dataIn;
  logic          regWrEn, reserveEn, ldStart, ldValid, ldReady, ldDone;
  logic [LN-1:0] wrMask;
  logic [RC-1:0] busy;
  logic [LW-1:0] ldData;

  vector_register_file #(.LANE_WIDTH(LW), .LANES(LN), .REG_COUNT(RC)) dut (
    .clk(clk), .reset(reset), .rSel1(rSel1), .rSel2(rSel2), .reg1Out(reg1Out), .reg2Out(reg2Out),
    .regWrEn(regWrEn), .regToWrite(regToWrite), .wrMask(wrMask), .dataIn(dataIn),
    .reserveEn(reserveEn), .reserveSel(reserveSel), .busy(busy), .ldStart(ldStart), .ldSel(ldSel),
    .ldValid(ldValid), .ldData(ldData), .ldReady(ldReady), .ldDone(ldDone)
  );

  always #5 clk = ~clk;

  // Reference model: plain lane array, busy flags and a "load in progress" record.
  logic [LW-1:0] m_mem [RC][LN];
  logic [RC-1:0] m_busy;
  logic          m_load, m_done;
  logic [SW-1:0] m_sel;
  int            m_cnt;
  int            vec_cnt = 0;
  int            err_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int r = 0; r < RC; r++) for (int l = 0; l < LN; l++) m_mem[r][l] = '0;
    m_busy = '0; m_load = 1'b0; m_done = 1'b0; m_sel = '0; m_cnt = 0;
  endtask

  function automatic logic [VW-1:0] m_read(input logic [SW-1:0] sel);
    logic [VW-1:0] v;
    for (int l = 0; l < LN; l++) begin
      v[l*LW +: LW] = m_mem[sel][l];
`ifdef VREG_WRITE_BYPASS_EN
      if (regWrEn && regToWrite == sel && wrMask[l]) v[l*LW +: LW] = dataIn[l*LW +: LW];
      if (m_load && ldValid && m_sel == sel && m_cnt == l) v[l*LW +: LW] = ldData;
`endif
    end
    return v;
  endfunction

  task automatic m_step();
    logic [RC-1:0] nb;
    bit beat, last;
    beat = m_load && ldValid;
    last = beat && (m_cnt == LN - 1);
    nb = m_busy;
    if (regWrEn && !(m_load && regToWrite == m_sel)) nb[regToWrite] = 1'b0;
    if (last) nb[m_sel] = 1'b0;
    if (!m_load && ldStart) nb[ldSel] = 1'b1;
    if (reserveEn) nb[reserveSel] = 1'b1;
    if (regWrEn)
      for (int l = 0; l < LN; l++) if (wrMask[l]) m_mem[regToWrite][l] = dataIn[l*LW +: LW];
    if (beat) m_mem[m_sel][m_cnt] = ldData;
    m_done = last;
    if (!m_load) begin
      if (ldStart) begin m_load = 1'b1; m_sel = ldSel; m_cnt = 0; end
    end else if (beat) begin
      if (last) begin m_load = 1'b0; m_cnt = 0; end
      else m_cnt++;
    end
    m_busy = nb;
  endtask

  task automatic check_all();
    check_val("reg1Out", reg1Out, m_read(rSel1));
    check_val("reg2Out", reg2Out, m_read(rSel2));
    check_val("busy", 32'(busy), 32'(m_busy));
    check_val("ldReady", 32'(ldReady), 32'(m_load));
    check_val("ldDone", 32'(ldDone), 32'(m_done));
  endtask

  // One clock: check outputs mid-low-phase, step the model on the edge, return at the next falling edge.
  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic idle();
    regWrEn = 1'b0; wrMask = '0; dataIn = '0; regToWrite = '0;
    reserveEn = 1'b0; reserveSel = '0; ldStart = 1'b0; ldSel = '0; ldValid = 1'b0; ldData = '0;
  endtask

  task automatic wr(input logic [SW-1:0] sel, input logic [LN-1:0] mask, input logic [VW-1:0] d);
    regWrEn = 1'b1; regToWrite = sel; wrMask = mask; dataIn = d;
  endtask

  logic [1:0]    beat_v [5] = '{2'd1, 2'd0, 2'd1, 2'd1, 2'd1};
  logic [LW-1:0] beat_d [5] = '{8'h11, 8'hEE, 8'h22, 8'h33, 8'h44};

  initial begin
    clk = 1'b0; reset = 1'b0; rSel1 = '0; rSel2 = '0;
    idle();
    m_reset();
    repeat (2) @(negedge clk);
    #1 check_all();
    check_val("rst busy", 32'(busy), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Full write then neighbour reads stay zero.
    wr(3'd3, 4'hF, 32'h04030201);
    cycle();
    idle(); rSel1 = 3'd3;
    #1 check_val("r3 full", reg1Out, 32'h04030201);
    for (int s = 0; s < RC; s++) if (s != 3) begin
      rSel2 = SW'(s);
      #1 check_val("other zero", reg2Out, 32'h0);
    end
    cycle();

    // Masked write keeps unmasked lanes.
    wr(3'd5, 4'hF, 32'hAABBCCDD); cycle();
    wr(3'd5, 4'b0101, 32'h11223344); cycle();
    idle(); rSel1 = 3'd5;
    #1 check_val("r5 masked", reg1Out, 32'hAA22CC44);
    cycle();

    // Reserve, then an empty-mask write clears busy without touching data.
    reserveEn = 1'b1; reserveSel = 3'd2; cycle();
    idle(); wr(3'd2, 4'h0, 32'hFFFFFFFF); rSel1 = 3'd2;
    #1 check_val("busy2 set", 32'(busy[2]), 32'h1);
    cycle();
    idle();
    #1 check_val("busy2 clr", 32'(busy[2]), 32'h0);
    check_val("r2 unchanged", reg1Out, 32'h0);
    cycle();

    // Same-cycle reserve and write on r2: set wins.
    reserveEn = 1'b1; reserveSel = 3'd2; wr(3'd2, 4'hF, 32'h12345678); cycle();
    idle();
    #1 check_val("set wins", 32'(busy[2]), 32'h1);
    wr(3'd2, 4'h0, 32'h0); cycle();
    idle();

    // Same-cycle read of the register being written.
    rSel1 = 3'd4; wr(3'd4, 4'hF, 32'h01020304);
`ifdef VREG_WRITE_BYPASS_EN
    #1 check_val("bypass", reg1Out, 32'h01020304);
`else
    #1 check_val("no bypass", reg1Out, 32'h0);
`endif
    cycle();
    idle();

    // Lane-serial load of r6 with a stall beat.
    ldStart = 1'b1; ldSel = 3'd6; cycle();
    idle();
    for (int i = 0; i < 5; i++) begin
      ldValid = beat_v[i][0]; ldData = beat_d[i];
      #1 check_val("ld ready", 32'(ldReady), 32'h1);
      check_val("ld busy6", 32'(busy[6]), 32'h1);
      cycle();
    end
    idle(); rSel1 = 3'd6;
    #1 check_val("ld done", 32'(ldDone), 32'h1);
    check_val("ld busy6 clr", 32'(busy[6]), 32'h0);
    check_val("ld ready off", 32'(ldReady), 32'h0);
    check_val("r6 loaded", reg1Out, 32'h44332211);
    cycle();
    #1 check_val("ld done pulse", 32'(ldDone), 32'h0);
    cycle();

    // Reset in the middle of a load of r1.
    ldStart = 1'b1; ldSel = 3'd1; cycle();
    idle(); ldValid = 1'b1; ldData = 8'hAA; cycle();
    ldData = 8'hBB; cycle();
    idle(); rSel1 = 3'd1; rSel2 = 3'd6;
    #1 reset = 1'b0;
    #1 check_val("abort busy", 32'(busy), 32'h0);
    check_val("abort ready", 32'(ldReady), 32'h0);
    check_val("abort r1", reg1Out, 32'h0);
    check_val("abort r6", reg2Out, 32'h0);
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rSel1      = SW'($urandom_range(0, RC - 1));
      rSel2      = SW'($urandom_range(0, RC - 1));
      regWrEn    = ($urandom_range(0, 1) == 1);
      regToWrite = SW'($urandom_range(0, RC - 1));
      wrMask     = LN'($urandom_range(0, 15));
      dataIn     = $urandom;
      reserveEn  = ($urandom_range(0, 4) == 0);
      reserveSel = SW'($urandom_range(0, RC - 1));
      ldStart    = ($urandom_range(0, 5) == 0);
      ldSel      = SW'($urandom_range(0, RC - 1));
      ldValid    = ($urandom_range(0, 9) < 6);
      ldData     = LW'($urandom_range(0, 255));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
